// File: rtl/mu01_prog_loader_if.sv
// Host byte stream and memory write port bundle for the MU01 program loader.
interface mu01_prog_loader_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_run;
    logic              done;
    logic              error;

    // Host / bench side: drives bytes and the re-arm pulse.
    modport master (
        output in_data, in_valid, start,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, error
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid, start,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, error
    );
endinterface

// File: rtl/mu01_prog_loader.sv
// MU01 program loader: frames a host byte stream (SYNC, ADDR, CNT, N words [, CHK]),
// writes 16-bit big-endian words into MU01 memory and releases the core once a
// complete image has loaded.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to add the trailing XOR checksum byte.
module mu01_prog_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic               clk,
    input  logic               reset_n,
    mu01_prog_loader_if.slave  bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned MAX_N = 1 << ADDR_W;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_AH   = 4'd1;
    localparam logic [3:0] S_AL   = 4'd2;
    localparam logic [3:0] S_CH   = 4'd3;
    localparam logic [3:0] S_CL   = 4'd4;
    localparam logic [3:0] S_DH   = 4'd5;
    localparam logic [3:0] S_DL   = 4'd6;
    localparam logic [3:0] S_DONE = 4'd8;
    localparam logic [3:0] S_ERR  = 4'd9;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [3:0] S_CHK  = 4'd7;
    localparam logic [3:0] S_LAST = S_CHK;
`else
    localparam logic [3:0] S_LAST = S_DONE;
`endif

    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic              w_accept;
    logic [15:0]       w_cnt_raw;
    logic [CNT_W-1:0]  w_cnt_clamped;
    logic [7:0]        r_hi;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_remain;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cpu_run;
    logic              r_done;
    logic              r_error;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        r_chk;
`endif

    assign w_accept      = bus.in_valid & r_in_ready;
    assign w_cnt_raw     = {r_hi, bus.in_data};
    assign w_cnt_clamped = (32'(w_cnt_raw) > MAX_N) ? CNT_W'(MAX_N) : CNT_W'(w_cnt_raw);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic: only accepted bytes advance; start re-arms the terminal states.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && bus.in_data == SYNC_BYTE) w_state_nxt = S_AH;
            S_AH:   if (w_accept) w_state_nxt = S_AL;
            S_AL:   if (w_accept) w_state_nxt = S_CH;
            S_CH:   if (w_accept) w_state_nxt = S_CL;
            S_CL:   if (w_accept) w_state_nxt = (w_cnt_raw == 16'd0) ? S_ERR : S_DH;
            S_DH:   if (w_accept) w_state_nxt = S_DL;
            S_DL:   if (w_accept) w_state_nxt = (r_remain == CNT_W'(1)) ? S_LAST : S_DH;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK:  if (w_accept) w_state_nxt = (bus.in_data == r_chk) ? S_DONE : S_ERR;
`endif
            S_DONE, S_ERR: if (bus.start) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, derived from the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi        <= 8'd0;
            r_ptr       <= '0;
            r_remain    <= '0;
            r_in_ready  <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_run   <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_chk       <= 8'd0;
`endif
        end else begin
            r_mem_we   <= 1'b0;
            r_in_ready <= (w_state_nxt != S_DONE) && (w_state_nxt != S_ERR);
            r_done     <= (w_state_nxt == S_DONE);
            r_cpu_run  <= (w_state_nxt == S_DONE);
            r_error    <= (w_state_nxt == S_ERR);
            if (w_accept) begin
                case (r_state)
`ifdef PROG_LOADER_CHECKSUM_EN
                    S_IDLE: r_chk <= 8'd0;
`endif
                    S_AH, S_CH: r_hi <= bus.in_data;
                    S_AL: r_ptr <= ADDR_W'(w_cnt_raw);
                    S_CL: r_remain <= w_cnt_clamped;
                    S_DH: begin
                        r_hi  <= bus.in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_chk <= r_chk ^ bus.in_data;
`endif
                    end
                    S_DL: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_ptr;
                        r_mem_wdata <= DATA_W'(w_cnt_raw);
                        r_ptr       <= r_ptr + ADDR_W'(1);
                        r_remain    <= r_remain - CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_chk       <= r_chk ^ bus.in_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_run   = r_cpu_run;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
endmodule
